// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcodes, FSM encoding and forwarding selects shared by the hazard controller.
package hazard_ctrl_pkg;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    typedef logic [1:0] hz_state_t;
    localparam hz_state_t ST_RUN    = 2'd0;
    localparam hz_state_t ST_LSTALL = 2'd1;
    localparam hz_state_t ST_MWAIT  = 2'd2;
    localparam hz_state_t ST_FLUSH  = 2'd3;
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR};
    endfunction
    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE};
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals of the hazard controller; slave is the controller.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
    logic [6:0] opcode_id;
    logic [REG_AW-1:0] rs1_id, rs2_id, rd_ex, rd_mem, rd_wb;
    logic mem_read_ex, reg_write_ex, reg_write_mem, reg_write_wb, take_branch_ex, mem_busy;
    logic pc_write, ifid_write, bubble_sel, kill_if, kill_dec;
    logic [1:0] fwd_a, fwd_b;
    modport master (
        output opcode_id, rs1_id, rs2_id, rd_ex, mem_read_ex, reg_write_ex, rd_mem, reg_write_mem,
               rd_wb, reg_write_wb, take_branch_ex, mem_busy,
        input  pc_write, ifid_write, bubble_sel, kill_if, kill_dec, fwd_a, fwd_b
    );
    modport slave (
        input  opcode_id, rs1_id, rs2_id, rd_ex, mem_read_ex, reg_write_ex, rd_mem, reg_write_mem,
               rd_wb, reg_write_wb, take_branch_ex, mem_busy,
        output pc_write, ifid_write, bubble_sel, kill_if, kill_dec, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: per-source EX/MEM and MEM/WB match with 2-bit forwarding select.
module hazard_ctrl_fwd_sel import hazard_ctrl_pkg::*; #(
    parameter int REG_AW = 5
) (
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              we_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              we_wb,
    output logic              hit_mem,
    output logic              hit_wb,
    output logic [1:0]        sel
);
    logic live;
    assign live    = use_rs && rs != '0;
    assign hit_mem = live && we_mem && rd_mem == rs;
    assign hit_wb  = live && we_wb && rd_wb == rs;
    assign sel     = hit_mem ? FWD_EXMEM : hit_wb ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/memory-wait stall FSM and forwarding selects for the 5-stage pipe.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
    parameter int REG_AW         = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int BRANCH_PENALTY = 2,
    parameter int FWD_EN         = 1
) (
    input logic clk,
    input logic rst_n,
    hazard_ctrl_if.slave hz
);
    // The decision cycle itself is the first stall/kill cycle, so the counters hold the remainder.
    localparam logic [2:0] LS_CNT = 3'(LOAD_STALL_CYC - 1);
    localparam logic [2:0] BR_CNT = 3'(BRANCH_PENALTY - 1);
    hz_state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic use1, use2, hit1_ex, hit2_ex, hit1_mem, hit2_mem, hit1_wb, hit2_wb;
    logic load_use, raw_stall, stall, pc_w, ifid_w, bub, kill;
    logic [1:0] sel_a, sel_b;
    assign use1 = uses_rs1(hz.opcode_id);
    assign use2 = uses_rs2(hz.opcode_id);
    assign hit1_ex = use1 && hz.rs1_id != '0 && hz.reg_write_ex && hz.rd_ex == hz.rs1_id;
    assign hit2_ex = use2 && hz.rs2_id != '0 && hz.reg_write_ex && hz.rd_ex == hz.rs2_id;
    hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel_a (
        .use_rs(use1), .rs(hz.rs1_id), .rd_mem(hz.rd_mem), .we_mem(hz.reg_write_mem),
        .rd_wb(hz.rd_wb), .we_wb(hz.reg_write_wb), .hit_mem(hit1_mem), .hit_wb(hit1_wb), .sel(sel_a)
    );
    hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel_b (
        .use_rs(use2), .rs(hz.rs2_id), .rd_mem(hz.rd_mem), .we_mem(hz.reg_write_mem),
        .rd_wb(hz.rd_wb), .we_wb(hz.reg_write_wb), .hit_mem(hit2_mem), .hit_wb(hit2_wb), .sel(sel_b)
    );
    assign load_use  = hz.mem_read_ex && (hit1_ex || hit2_ex);
    // Without forwarding any RAW simply holds ID until the producer leaves WB.
    assign raw_stall = FWD_EN == 0 && (hit1_ex || hit2_ex || hit1_mem || hit2_mem || hit1_wb || hit2_wb);
    assign stall     = load_use || raw_stall;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_w     = 1'b0;
        ifid_w   = 1'b0;
        bub      = 1'b0;
        kill     = 1'b0;
        if (hz.mem_busy) begin
            state_nx = state == ST_FLUSH ? ST_FLUSH : ST_MWAIT;
        end else if (state == ST_FLUSH) begin
            {pc_w, ifid_w, bub, kill} = 4'b1111;
            state_nx = cnt <= 3'd1 ? ST_RUN : ST_FLUSH;
            cnt_nx   = cnt - 3'd1;
        end else if (hz.take_branch_ex) begin
            {pc_w, ifid_w, bub, kill} = 4'b1111;
            state_nx = BR_CNT == 3'd0 ? ST_RUN : ST_FLUSH;
            cnt_nx   = BR_CNT;
        end else if (state == ST_LSTALL) begin
            bub      = 1'b1;
            state_nx = cnt <= 3'd1 ? ST_RUN : ST_LSTALL;
            cnt_nx   = cnt - 3'd1;
        end else if (stall) begin
            bub      = 1'b1;
            state_nx = load_use && LS_CNT != 3'd0 ? ST_LSTALL : ST_RUN;
            cnt_nx   = LS_CNT;
        end else begin
            {pc_w, ifid_w} = 2'b11;
            state_nx = ST_RUN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FLUSH;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    assign hz.pc_write   = rst_n && pc_w;
    assign hz.ifid_write = rst_n && ifid_w;
    assign hz.bubble_sel = !rst_n || bub;
    assign hz.kill_if    = !rst_n || kill;
    assign hz.kill_dec   = !rst_n || kill;
    assign hz.fwd_a      = rst_n && FWD_EN != 0 ? sel_a : FWD_RF;
    assign hz.fwd_b      = rst_n && FWD_EN != 0 ? sel_b : FWD_RF;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, flush, memory-wait, forwarding and reset behaviour.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    hazard_ctrl_if #(.REG_AW(5)) hz ();
    hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYC(2), .BRANCH_PENALTY(2), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );
    always #5 clk = ~clk;
    // ctl vector order: {pc_write, ifid_write, bubble_sel, kill_if, kill_dec}
    localparam logic [4:0] C_RUN = 5'b11000, C_STL = 5'b00100, C_FRZ = 5'b00000;
    localparam logic [4:0] C_KIL = 5'b11111, C_RST = 5'b00111;
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {hz.pc_write, hz.ifid_write, hz.bubble_sel, hz.kill_if, hz.kill_dec};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: ctl got %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        checks++;
        assert ({hz.fwd_a, hz.fwd_b} === {ea, eb}) else begin
            errors++;
            $error("FAIL %s: fwd_a/fwd_b got %0d/%0d expected %0d/%0d", tag, hz.fwd_a, hz.fwd_b, ea, eb);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic id_ex(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rdx, input logic ld);
        hz.opcode_id    = op;
        hz.rs1_id       = r1;
        hz.rs2_id       = r2;
        hz.rd_ex        = rdx;
        hz.mem_read_ex  = ld;
        hz.reg_write_ex = ld;
    endtask
    task automatic mem_wb(input logic [4:0] rm, input logic wm, input logic [4:0] rw, input logic ww);
        hz.rd_mem        = rm;
        hz.reg_write_mem = wm;
        hz.rd_wb         = rw;
        hz.reg_write_wb  = ww;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        id_ex(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        mem_wb(5'd0, 1'b0, 5'd0, 1'b0);
        hz.take_branch_ex = 1'b0;
        hz.mem_busy = 1'b0;
        #3;
        chk_ctl("reset_ctl", C_RST);
        chk_fwd("reset_fwd", 2'd0, 2'd0);
        cyc();
        rst_n = 1'b1;
        #2;
        chk_ctl("post_release_flush", C_KIL);
        cyc(); #2;
        chk_ctl("run_idle", C_RUN);
        // add x3,x1,x2 behind ld x1: two stall cycles
        cyc(); id_ex(OPCODE_OP, 5'd1, 5'd2, 5'd1, 1'b1); #2;
        chk_ctl("load_use_1", C_STL);
        cyc(); id_ex(OPCODE_OP, 5'd1, 5'd2, 5'd0, 1'b0); #2;
        chk_ctl("load_use_2", C_STL);
        cyc(); #2;
        chk_ctl("load_use_done", C_RUN);
        cyc(); id_ex(OPCODE_OP_IMM, 5'd0, 5'd1, 5'd0, 1'b1); #2;
        chk_ctl("x0_exempt", C_RUN);
        id_ex(OPCODE_OP_IMM, 5'd3, 5'd7, 5'd7, 1'b1); #1;
        chk_ctl("opimm_rs2_unused", C_RUN);
        id_ex(OPCODE_LUI, 5'd7, 5'd7, 5'd7, 1'b1); #1;
        chk_ctl("lui_no_src", C_RUN);
        id_ex(OPCODE_STORE, 5'd3, 5'd7, 5'd7, 1'b1); #1;
        chk_ctl("store_rs2_stall", C_STL);
        cyc(); id_ex(OPCODE_STORE, 5'd3, 5'd7, 5'd0, 1'b0); #2;
        chk_ctl("store_stall_2", C_STL);
        cyc(); #2;
        chk_ctl("store_done", C_RUN);
        // taken branch: two kill cycles
        cyc(); id_ex(OPCODE_LUI, 5'd0, 5'd0, 5'd0, 1'b0); hz.take_branch_ex = 1'b1; #2;
        chk_ctl("branch_k1", C_KIL);
        cyc(); hz.take_branch_ex = 1'b0; #2;
        chk_ctl("branch_k2", C_KIL);
        cyc(); #2;
        chk_ctl("branch_done", C_RUN);
        // branch preempts LSTALL
        cyc(); id_ex(OPCODE_OP, 5'd1, 5'd2, 5'd1, 1'b1); #2;
        chk_ctl("pre_stall", C_STL);
        cyc(); id_ex(OPCODE_OP, 5'd1, 5'd2, 5'd0, 1'b0); hz.take_branch_ex = 1'b1; #2;
        chk_ctl("preempt_k1", C_KIL);
        cyc(); hz.take_branch_ex = 1'b0; #2;
        chk_ctl("preempt_k2", C_KIL);
        cyc(); #2;
        chk_ctl("preempt_done", C_RUN);
        // mem_busy freezes FLUSH with cnt held
        cyc(); id_ex(OPCODE_LUI, 5'd0, 5'd0, 5'd0, 1'b0); hz.take_branch_ex = 1'b1; #2;
        chk_ctl("mb_branch", C_KIL);
        cyc(); hz.take_branch_ex = 1'b0; hz.mem_busy = 1'b1; #2;
        chk_ctl("mb_frz1", C_FRZ);
        cyc(); #2;
        chk_ctl("mb_frz2", C_FRZ);
        cyc(); #2;
        chk_ctl("mb_frz3", C_FRZ);
        cyc(); hz.mem_busy = 1'b0; #2;
        chk_ctl("mb_flush_left", C_KIL);
        cyc(); #2;
        chk_ctl("mb_flush_done", C_RUN);
        // mem_busy outranks load_use; pending load_use resolved after wait
        cyc(); id_ex(OPCODE_OP, 5'd1, 5'd2, 5'd2, 1'b1); hz.mem_busy = 1'b1; #2;
        chk_ctl("mw_prio", C_FRZ);
        cyc(); #2;
        chk_ctl("mw_hold", C_FRZ);
        cyc(); hz.mem_busy = 1'b0; #2;
        chk_ctl("mw_reeval", C_STL);
        cyc(); id_ex(OPCODE_OP, 5'd1, 5'd2, 5'd0, 1'b0); #2;
        chk_ctl("mw_stall2", C_STL);
        cyc(); #2;
        chk_ctl("mw_done", C_RUN);
        // forwarding
        cyc(); id_ex(OPCODE_OP, 5'd4, 5'd6, 5'd0, 1'b0); mem_wb(5'd4, 1'b1, 5'd4, 1'b1); #2;
        chk_fwd("fwd_double", 2'd1, 2'd0);
        chk_ctl("fwd_no_stall", C_RUN);
        hz.reg_write_mem = 1'b0; #1;
        chk_fwd("fwd_wb", 2'd2, 2'd0);
        mem_wb(5'd6, 1'b1, 5'd4, 1'b1); #1;
        chk_fwd("fwd_split", 2'd2, 2'd1);
        id_ex(OPCODE_OP_IMM, 5'd4, 5'd6, 5'd0, 1'b0); #1;
        chk_fwd("fwd_rs2_unused", 2'd2, 2'd0);
        id_ex(OPCODE_OP, 5'd0, 5'd6, 5'd0, 1'b0); mem_wb(5'd0, 1'b1, 5'd0, 1'b1); #1;
        chk_fwd("fwd_x0", 2'd0, 2'd0);
        id_ex(OPCODE_OP, 5'd4, 5'd6, 5'd4, 1'b1); mem_wb(5'd4, 1'b1, 5'd0, 1'b0); #1;
        chk_fwd("fwd_with_load", 2'd1, 2'd0);
        chk_ctl("fwd_keeps_stall", C_STL);
        // reset mid-LSTALL
        cyc(); #2;
        chk_ctl("rst_pre_lstall", C_STL);
        rst_n = 1'b0; #1;
        chk_ctl("rst_mid_ctl", C_RST);
        chk_fwd("rst_mid_fwd", 2'd0, 2'd0);
        id_ex(OPCODE_OP, 5'd4, 5'd6, 5'd0, 1'b0); mem_wb(5'd0, 1'b0, 5'd0, 1'b0);
        cyc(); rst_n = 1'b1; #2;
        chk_ctl("rst_release_flush", C_KIL);
        cyc(); #2;
        chk_ctl("rst_run", C_RUN);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
